// File: rtl/imem_responder.sv
// Instruction-memory responder: 64-bit fetch packets plus a 32-bit word loader that holds the core.
// Latency: 1 cycle from addr_i to data_o; loader accepts one word per cycle, last word to RUN in 2 edges.
// Backpressure: ld_ready_o only in LOAD_HI/LOAD_LO; core_hold_o stalls the core. Optional IMEM_PARITY_EN.
module imem_responder #(
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = 10,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              fetch_en_i,
    output logic [63:0]       data_o,
    output logic              core_hold_o,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ovf_o,
    output logic              perr_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [ADDR_W:0]     wp_q;
    logic [31:0]         hi_q;
    logic [63:0]         data_q;
    logic                ovf_q;

    logic [63:0]         mem [DEPTH];
    logic [63:0]         rd_line;

    logic                ld_fire;
    logic                mem_we;
    logic [ADDR_W-1:0]   wr_line;
    logic [63:0]         wr_dat;
    logic                data_upd;
    logic                data_nop;

    assign ld_ready_o  = (state_q == LOAD_HI) || (state_q == LOAD_LO);
    assign core_hold_o = (state_q != RUN);
    assign ld_fire     = ld_valid_i && ld_ready_o;
    assign rd_line     = mem[addr_i];
    assign wr_line     = wp_q[ADDR_W:1];

    always_comb begin
        state_nxt = state_q;
        mem_we    = 1'b0;
        wr_dat    = {hi_q, ld_data_i};
        data_upd  = 1'b0;
        data_nop  = 1'b0;
        case (state_q)
            RUN: begin
                if (ld_valid_i) begin
                    state_nxt = LOAD_HI;
                    data_nop  = 1'b1;
                end else if (fetch_en_i) begin
                    data_upd  = 1'b1;
                end
            end
            LOAD_HI: begin
                if (ld_fire) begin
                    if (ld_last_i) begin
                        // Odd-length load: pad the lower slot of the final line
                        mem_we    = 1'b1;
                        wr_dat    = {ld_data_i, NOP};
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (ld_fire) begin
                    mem_we    = 1'b1;
                    wr_dat    = {hi_q, ld_data_i};
                    state_nxt = ld_last_i ? DRAIN : LOAD_HI;
                end
            end
            DRAIN: begin
                data_upd  = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= RUN;
            wp_q    <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_q == RUN && ld_valid_i) begin
                wp_q <= '0;
            end else if (ld_fire) begin
                wp_q <= wp_q + 1'b1;
                if (&wp_q) begin
                    ovf_q <= 1'b1;
                end
                if (state_q == LOAD_HI) begin
                    hi_q <= ld_data_i;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_q <= {NOP, NOP};
        end else if (data_nop) begin
            data_q <= {NOP, NOP};
        end else if (data_upd) begin
            data_q <= rd_line;
        end
    end

    // Storage is never reset; a write coinciding with reset is dropped
    always_ff @(posedge clock_i) begin
        if (mem_we && !reset_i) begin
            mem[wr_line] <= wr_dat;
        end
    end

`ifdef IMEM_PARITY_EN
    logic [1:0] par_mem [DEPTH];
    logic [1:0] rd_par;
    logic       rd_perr;
    logic       perr_q;

    assign rd_par  = par_mem[addr_i];
    assign rd_perr = ((^rd_line[63:32]) ^ rd_par[1]) | ((^rd_line[31:0]) ^ rd_par[0]);

    always_ff @(posedge clock_i) begin
        if (mem_we && !reset_i) begin
            par_mem[wr_line] <= {^wr_dat[63:32], ^wr_dat[31:0]};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            perr_q <= 1'b0;
        end else if (data_nop) begin
            perr_q <= 1'b0;
        end else if (data_upd) begin
            perr_q <= rd_perr;
        end
    end

    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

    assign data_o   = data_q;
    assign ld_ovf_o = ovf_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a line-array reference model.
module tb_imem_responder;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 2;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [63:0] NOP2   = {NOP, NOP};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic              fetch_en = 1'b0;
    logic [63:0]       data_o;
    logic              core_hold;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [31:0]       ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ovf;
    logic              perr;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [DEPTH];
    logic        ovf_m = 1'b0;
    logic [31:0] words_q [$];

    imem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(NOP)) dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .addr_i      (addr),
        .fetch_en_i  (fetch_en),
        .data_o      (data_o),
        .core_hold_o (core_hold),
        .ld_valid_i  (ld_valid),
        .ld_ready_o  (ld_ready),
        .ld_data_i   (ld_data),
        .ld_last_i   (ld_last),
        .ld_ovf_o    (ld_ovf),
        .perr_o      (perr)
    );

    always #5 clk = ~clk;

    // Reference: word k of a load lands in line (k/2) mod DEPTH, even k in the upper half.
    task automatic model_load();
        int n = words_q.size();
        for (int i = 0; i < n; i += 2) begin
            mdl[(i / 2) % DEPTH] = {words_q[i], (i + 1 < n) ? words_q[i + 1] : NOP};
        end
        if (n > 2 * DEPTH) ovf_m = 1'b1;
    endtask

    task automatic make_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Called at a negedge; returns at the negedge where the core is released.
    task automatic drive_load(input string name);
        int n = words_q.size();
        int guard;
        int gap;
        fetch_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            ld_valid = 1'b0;
            repeat (gap) @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = words_q[i];
            ld_last  = (i == n - 1);
            guard = 0;
            while (!ld_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (guard >= 20) begin
                $display("FAIL %s_ready_timeout: ld_ready_o=%b required 1", name, ld_ready);
                errors++;
                break;
            end
            checks++;
            if (data_o !== NOP2 || core_hold !== 1'b1) begin
                $display("FAIL %s_loading: data_o=%h hold=%b required %h hold=1",
                         name, data_o, core_hold, NOP2);
                errors++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (core_hold !== 1'b1 || ld_ready !== 1'b0) begin
            $display("FAIL %s_drain: hold=%b ready=%b required hold=1 ready=0", name, core_hold, ld_ready);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (core_hold !== 1'b0) begin
            $display("FAIL %s_release: hold=%b required 0", name, core_hold);
            errors++;
        end
        model_load();
        checks++;
        if (ld_ovf !== ovf_m) begin
            $display("FAIL %s_ovf: ld_ovf_o=%b required %b", name, ld_ovf, ovf_m);
            errors++;
        end
    endtask

    task automatic fetch_chk(input int line, input string name);
        addr     = ADDR_W'(line);
        fetch_en = 1'b1;
        @(negedge clk);
        checks++;
        if (data_o !== mdl[line]) begin
            $display("FAIL %s: data_o=%h required %h", name, data_o, mdl[line]);
            errors++;
        end
        checks++;
        if (perr !== 1'b0) begin
            $display("FAIL %s_perr: perr_o=%b required 0", name, perr);
            errors++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ovf_m = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (data_o !== NOP2 || core_hold !== 1'b0 || ld_ready !== 1'b0 ||
                ld_ovf !== 1'b0 || perr !== 1'b0) begin
                $display("FAIL reset_state: data_o=%h hold=%b ready=%b ovf=%b perr=%b required %h 0 0 0 0",
                         data_o, core_hold, ld_ready, ld_ovf, perr, NOP2);
                errors++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_load();
        make_words(4);
        drive_load("full");
        fetch_chk(0, "full_line0");
        fetch_chk(1, "full_line1");
    endtask

    task automatic test_odd_load();
        make_words(3);
        drive_load("odd");
        fetch_chk(1, "odd_line1");
        fetch_chk(0, "odd_line0");
    endtask

    task automatic test_fetch_stall();
        fetch_chk(0, "stall_pre");
        fetch_en = 1'b0;
        addr     = ADDR_W'(1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (data_o !== mdl[0]) begin
                $display("FAIL stall_hold: data_o=%h required %h", data_o, mdl[0]);
                errors++;
            end
        end
        fetch_chk(1, "stall_resume");
    endtask

    task automatic test_reset_midload();
        fetch_en = 1'b0;
        ld_valid = 1'b1;
        ld_data  = $urandom;
        ld_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1) begin
            $display("FAIL midload_lo_ready: ld_ready_o=%b required 1", ld_ready);
            errors++;
        end
        ld_data = $urandom;
        reset   = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b0;
        ovf_m    = 1'b0;
        checks++;
        if (ld_ready !== 1'b0 || core_hold !== 1'b0 || data_o !== NOP2 || ld_ovf !== 1'b0) begin
            $display("FAIL midload_reset: ready=%b hold=%b data_o=%h ovf=%b required 0 0 %h 0",
                     ld_ready, core_hold, data_o, ld_ovf, NOP2);
            errors++;
        end
        fetch_chk(0, "midload_keep0");
        fetch_chk(1, "midload_keep1");
    endtask

    task automatic test_random();
        logic [63:0] exp_d;
        logic        en;
        int          a;
        make_words(7);
        drive_load("rand_init");
        for (int it = 0; it < 4; it++) begin
            make_words($urandom_range(1, 7));
            drive_load("rand_load");
            fetch_chk(0, "rand_sync");
            exp_d = mdl[0];
            for (int k = 0; k < 20; k++) begin
                en = 1'($urandom_range(0, 1));
                a  = $urandom_range(0, DEPTH - 1);
                fetch_en = en;
                addr     = ADDR_W'(a);
                @(negedge clk);
                if (en) exp_d = mdl[a];
                checks++;
                if (data_o !== exp_d) begin
                    $display("FAIL rand_fetch: addr=%0d en=%b data_o=%h required %h", a, en, data_o, exp_d);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_wrap();
        make_words(9);
        drive_load("wrap");
        checks++;
        if (ld_ovf !== 1'b1) begin
            $display("FAIL wrap_ovf: ld_ovf_o=%b required 1", ld_ovf);
            errors++;
        end
        checks++;
        if (mdl[0] !== {words_q[8], NOP}) begin
            $display("FAIL wrap_model: model line0=%h required %h", mdl[0], {words_q[8], NOP});
            errors++;
        end
        for (int l = 0; l < DEPTH; l++) fetch_chk(l, "wrap_line");
    endtask

    task automatic test_parity();
`ifdef IMEM_PARITY_EN
        make_words(2);
        drive_load("par");
        fetch_chk(0, "par_clean");
        dut.mem[0][40] = ~dut.mem[0][40];
        mdl[0][40]     = ~mdl[0][40];
        addr     = '0;
        fetch_en = 1'b1;
        @(negedge clk);
        checks++;
        if (data_o !== mdl[0] || perr !== 1'b1) begin
            $display("FAIL par_flip: data_o=%h perr=%b required %h perr=1", data_o, perr, mdl[0]);
            errors++;
        end
`else
        fetch_chk(1, "par_absent");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_full_load();
        test_odd_load();
        test_fetch_stall();
        test_reset_midload();
        test_random();
        test_wrap();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
